hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage core. It works beside the EX-stage operand forwarding unit and covers the hazards forwarding cannot resolve:
- load-use dependencies,
- taken-branch/jump redirects,
- multi-cycle mul/div occupancy in EX,
- data-memory wait states in MEM.

It drives per-stage stall (hold) and flush (bubble) controls, and keeps a stall-cycle performance counter and a mul/div watchdog.

Parameters:
REG_AW, 5, register-index width (matches rs/rd fields)
MD_TIMEOUT, 64, max cycles in MD_WAIT before watchdog fires (>=2)
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
rs1_id  in  REG_AW  rs1 of instruction in ID
rs2_id  in  REG_AW  rs2 of instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_ex  in  REG_AW  destination of instruction in EX
memread_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  EX resolved a taken branch/jump (PC redirect)
md_req_ex  in  1  EX instruction is mul/div, operands valid
md_done  in  1  mul/div unit result valid (1-cycle pulse)
dmem_req_mem  in  1  MEM instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
stall_ex  out  1  hold ID/EX register
stall_mem  out  1  hold EX/MEM register
flush_id  out  1  bubble into IF/ID
flush_ex  out  1  bubble into ID/EX
flush_mem  out  1  bubble into EX/MEM
flush_wb  out  1  bubble into MEM/WB
md_go  out  1  start pulse to mul/div unit
md_timeout  out  1  sticky watchdog error
stall_cnt  out  CNT_W  cycles with stall_if==1, saturating

Behaviour:
- State register {RUN, MD_WAIT}. Reset: state=RUN, md_cnt=0, md_timeout=0, stall_cnt=0.
- All control outputs are combinational from state and inputs. While rst==0, every output is 0 except the registered values, which show their reset values.
- Load-use hazard, defined: lu = memread_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
- Priority, highest first, evaluated every cycle:
  1. dmem wait (dmem_req_mem & !dmem_ready), any state: stall_if, stall_id, stall_ex, stall_mem=1; flush_wb=1; all other controls 0. No state change. md_cnt still counts in MD_WAIT.
  2. MD_WAIT & !md_done: stall_if, stall_id, stall_ex=1; flush_mem=1.
  3. MD_WAIT & md_done: no stall. Next state RUN; md_cnt cleared.
  4. RUN & md_req_ex: md_go=1 for exactly this cycle; stall_if, stall_id, stall_ex=1; flush_mem=1. Next state MD_WAIT.
  5. RUN & branch_taken_ex: flush_id=1, flush_ex=1, no stalls. Any lu is ignored because the ID instruction is squashed.
  6. RUN & lu: stall_if, stall_id=1; flush_ex=1 for one cycle. After one cycle the load is in MEM and the forwarding unit resolves the dependency.
  7. Otherwise all controls 0.
- md_req_ex and branch_taken_ex are mutually exclusive by decode. If both are high, md_req_ex wins and the branch is ignored.
- md_cnt counts cycles spent in MD_WAIT.
  - If md_cnt reaches MD_TIMEOUT-1 while md_done is low, and no dmem wait is active that cycle: md_timeout is set and stays set until reset. Next state is RUN. That cycle outputs flush_ex=1 and flush_mem=1 with no stalls, discarding the mul/div instruction.
  - A dmem wait in the timeout cycle defers the timeout to the first non-dmem-wait cycle.
- md_done seen in RUN is ignored.
- stall_cnt increments by 1 on each cycle where stall_if==1 and rst==1. It holds at all-ones on saturation.
- Mid-operation reset: MD_WAIT returns to RUN, and all controls drop to 0 in the reset cycle.

Test Plan:
- Load-use: memread_ex=1, rd_ex=5, rs2_id=5, rs2_used_id=1 -> one cycle with stall_if=stall_id=flush_ex=1, then all 0; stall_cnt=1. Repeat with rd_ex=0 or rs2_used_id=0 -> no stall.
- Redirect beats load-use: the load-use case plus branch_taken_ex=1 -> flush_id=flush_ex=1, stall_if=0, stall_cnt unchanged.
- Mul/div: md_req_ex=1 in RUN -> md_go=1 for 1 cycle, then MD_WAIT with stall_if/id/ex=1 and flush_mem=1. md_done on the 4th wait cycle -> stalls drop that cycle, state RUN, stall_cnt=4.
- Dmem wait inside MD_WAIT: dmem_ready=0 for 3 cycles -> stall_mem=1 and flush_wb=1, flush_mem=0; state stays MD_WAIT. After release, md_done completes normally.
- Watchdog: MD_TIMEOUT=8, md_req_ex then no md_done -> on the 8th MD_WAIT cycle md_timeout=1, flush_ex=flush_mem=1, state RUN. md_timeout persists until rst=0.
- Reset mid-MD_WAIT: rst=0 for 1 cycle -> all outputs 0, stall_cnt=0, md_timeout=0, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller.
// Stall/flush control for load-use, redirect, mul/div and dmem wait.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              memread_ex,
    input  logic              branch_taken_ex,
    input  logic              md_req_ex,
    input  logic              md_done,
    input  logic              dmem_req_mem,
    input  logic              dmem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic              flush_wb,
    output logic              md_go,
    output logic              md_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int MCW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [MCW-1:0] MC_LAST = MCW'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [MCW-1:0]   md_cnt_q, md_cnt_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cnt_q;

    logic dm_wait;
    logic lu;
    logic md_fire;
    logic in_wait;

    assign in_wait = (state_q == MD_WAIT);
    assign dm_wait = dmem_req_mem & ~dmem_ready;
    assign lu = memread_ex & (rd_ex != '0) &
                ((rs1_used_id & (rs1_id == rd_ex)) |
                 (rs2_used_id & (rs2_id == rd_ex)));
    assign md_fire = in_wait & ~md_done & (md_cnt_q == MC_LAST);

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        flush_wb  = 1'b0;
        md_go     = 1'b0;
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        to_d      = to_q;
        if (rst) begin
            priority case (1'b1)
                dm_wait: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    flush_wb  = 1'b1;
                    // Counter parks at the limit so the timeout fires
                    // on the first cycle after the dmem wait clears.
                    if (in_wait && md_cnt_q != MC_LAST)
                        md_cnt_d = md_cnt_q + MCW'(1);
                end
                in_wait && md_done: begin
                    state_d  = RUN;
                    md_cnt_d = '0;
                end
                md_fire: begin
                    flush_ex  = 1'b1;
                    flush_mem = 1'b1;
                    to_d      = 1'b1;
                    state_d   = RUN;
                    md_cnt_d  = '0;
                end
                in_wait: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    flush_mem = 1'b1;
                    md_cnt_d  = md_cnt_q + MCW'(1);
                end
                md_req_ex: begin
                    md_go     = 1'b1;
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    flush_mem = 1'b1;
                    state_d   = MD_WAIT;
                    md_cnt_d  = '0;
                end
                branch_taken_ex: begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                end
                lu: begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            to_q     <= to_d;
            if (stall_if && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Registered outputs read as their reset values while rst is low.
    assign md_timeout = to_q & rst;
    assign stall_cnt  = rst ? cnt_q : '0;

endmodule
